if_prefetch: RTL and testbench

Parametrised instruction-fetch stage for the MIPS R2000 pipeline, sitting between the instruction memory and ID. It runs ahead of decode by issuing in-order requests to an instruction memory of arbitrary latency and buffering the returned words with their PCs in a DEPTH-entry prefetch queue. It presents one instruction per cycle to ID and handles stall (`hold_pc`/`hold_if`), branch redirect and exception redirect, including discarding responses already in flight.

---
 rtl/mips_pkg.sv | 14 +
 rtl/fetch_queue.sv | 79 +++++++
 rtl/if_prefetch.sv | 116 +++++++++++
 tb/tb_if_prefetch.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS R2000 front end.
// Fetch entries pair each instruction word with the PC it was fetched from.
package mips_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam logic [31:0] EXCEPT_VEC = 32'h8000_0080;
  localparam logic [31:0] RESET_VEC  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, inst} entries plus an in-order tag FIFO holding the
// address of every request still waiting for its memory response.
module fetch_queue
  import mips_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tag_push_i,
  input  logic [31:0]  tag_pc_i,
  input  logic         rsp_i,
  input  logic         rsp_keep_i,
  input  logic [31:0]  rsp_inst_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [31:0]   tag_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] tag_wr_q, tag_rd_q;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;

  // Every response retires a tag, even a discarded one, so tags stay aligned.
  assign push = rsp_i && rsp_keep_i && !flush_i;
  assign pop  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (tag_push_i) tag_wr_q <= tag_wr_q + PW'(1);
      if (rsp_i)      tag_rd_q <= tag_rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)       mem_q[wr_ptr_q] <= {tag_q[tag_rd_q], rsp_inst_i};
    if (tag_push_i) tag_q[tag_wr_q] <= tag_pc_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: runs ahead of ID through a prefetch queue, handles
// stalls and branch/exception redirects, and drops responses to stale fetches.
module if_prefetch
  import mips_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_VEC,
  parameter logic [XLEN-1:0] EXCEPT_PC = EXCEPT_VEC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold_pc,
  input  logic            hold_if,
  input  logic            br,
  input  logic [XLEN-1:0] pc_branch,
  input  logic            except,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_data,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] inst_out,
  output logic            inst_valid
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] inst_out_q, inst_out_d;
  logic            inst_valid_q, inst_valid_d;
  logic [CW-1:0]   q_count;
  logic [CW:0]     in_use;
  logic            redirect;
  logic            keep;
  logic            pop;
  fetch_entry_t    head;

  // Memory handshake: imem_req has no ready; memory takes every request and
  // answers each with exactly one imem_valid pulse, in request order.
  assign redirect  = except | br;
  assign in_use    = {1'b0, q_count} + {1'b0, outstanding_q};
  assign imem_req  = !rst && !hold_pc && !redirect && (in_use < (CW+1)'(DEPTH));
  assign imem_addr = fpc_q;
  assign keep      = !redirect && (discard_q == '0);
  assign pop       = !hold_if && !redirect && (q_count != '0);

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .tag_push_i (imem_req),
    .tag_pc_i   (imem_addr),
    .rsp_i      (imem_valid),
    .rsp_keep_i (keep),
    .rsp_inst_i (imem_data),
    .pop_i      (pop),
    .flush_i    (redirect),
    .count_o    (q_count),
    .head_o     (head)
  );

  always_comb begin
    fpc_d         = fpc_q;
    outstanding_d = outstanding_q + CW'(imem_req) - CW'(imem_valid);
    discard_d     = discard_q;
    pc_out_d      = pc_out_q;
    inst_out_d    = inst_out_q;
    inst_valid_d  = inst_valid_q;
    if (redirect) begin
      fpc_d        = except ? EXCEPT_PC : pc_branch;
      // Whatever is still in flight after this cycle belongs to the old path.
      discard_d    = outstanding_q - CW'(imem_valid);
      inst_out_d   = NOP_INST;
      inst_valid_d = 1'b0;
    end else begin
      if (imem_req) fpc_d = fpc_q + XLEN'(4);
      if (imem_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (!hold_if) begin
        if (q_count != '0) begin
          pc_out_d     = head.pc;
          inst_out_d   = head.inst;
          inst_valid_d = 1'b1;
        end else begin
          inst_out_d   = NOP_INST;
          inst_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q         <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      pc_out_q      <= '0;
      inst_out_q    <= '0;
      inst_valid_q  <= 1'b0;
    end else begin
      fpc_q         <= fpc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      pc_out_q      <= pc_out_d;
      inst_out_q    <= inst_out_d;
      inst_valid_q  <= inst_valid_d;
    end
  end

  assign pc_out     = pc_out_q;
  assign inst_out   = inst_out_q;
  assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: a variable-latency memory returning inst = addr, and a
// stream-level reference model of fetched, in-flight and buffered instructions.
module tb_if_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_PC   = 32'h8000_0080;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        hold_pc    = 1'b0;
  logic        hold_if    = 1'b0;
  logic        br         = 1'b0;
  logic        except     = 1'b0;
  logic [31:0] pc_branch  = 32'h0;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_data  = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid;

  if_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .EXCEPT_PC(EXC_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold_pc    (hold_pc),
    .hold_if    (hold_if),
    .br         (br),
    .pc_branch  (pc_branch),
    .except     (except),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .pc_out     (pc_out),
    .inst_out   (inst_out),
    .inst_valid (inst_valid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          t;
  } mreq_t;

  mreq_t mem_q[$];
  int    edge_cnt = 0;
  int    mem_lat  = 1;
  bit    mem_hold = 1'b0;
  bit    mem_gap  = 1'b0;

  always begin
    @(posedge clk);
    if (rst) mem_q.delete();
    else if (imem_req) mem_q.push_back('{imem_addr, edge_cnt});
    edge_cnt++;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data  = 32'hDEAD_BEEF;
    if (mem_q.size() > 0 && !mem_hold && edge_cnt >= mem_q[0].t + mem_lat &&
        !(mem_gap && $urandom_range(0, 2) == 0)) begin
      imem_valid = 1'b1;
      imem_data  = mem_q[0].addr;
      void'(mem_q.pop_front());
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } flight_t;

  logic [63:0] exp_q[$];   // buffered {pc, inst} not yet handed to ID
  flight_t     fl_q[$];    // requests issued, response not yet seen
  logic [31:0] m_fpc   = RESET_PC;
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_inst  = 32'h0;
  logic        m_valid = 1'b0;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] seq_pc  = RESET_PC;
  bit          got;

  logic [97:0] dut_vec;
  assign dut_vec = {imem_req, imem_req ? imem_addr : 32'h0, inst_valid, pc_out, inst_out};

  function automatic logic [97:0] exp_vec();
    logic r;
    r = !rst && !hold_pc && !(br || except) && (exp_q.size() + fl_q.size() < DEPTH);
    return {r, r ? m_fpc : 32'h0, m_valid, m_pc, m_inst};
  endfunction

  // One clock edge of the intended behaviour, using the inputs seen at that edge.
  task automatic model_step();
    logic        redir;
    logic        take;
    logic [63:0] e;
    flight_t     f;
    if (rst) begin
      exp_q.delete();
      fl_q.delete();
      m_fpc   = RESET_PC;
      m_pc    = 32'h0;
      m_inst  = 32'h0;
      m_valid = 1'b0;
      return;
    end
    redir = br || except;
    take  = !hold_pc && !redir && (exp_q.size() + fl_q.size() < DEPTH);
    if (redir) begin
      m_valid = 1'b0;
      m_inst  = 32'h0;
    end else if (!hold_if) begin
      if (exp_q.size() > 0) begin
        e       = exp_q.pop_front();
        m_pc    = e[63:32];
        m_inst  = e[31:0];
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
        m_inst  = 32'h0;
      end
    end
    if (imem_valid && fl_q.size() > 0) begin
      f = fl_q.pop_front();
      if (!f.stale && !redir) exp_q.push_back({f.pc, imem_data});
    end
    if (redir) begin
      exp_q.delete();
      foreach (fl_q[i]) fl_q[i].stale = 1'b1;
      m_fpc = except ? EXC_PC : pc_branch;
    end else if (take) begin
      fl_q.push_back('{m_fpc, 1'b0});
      m_fpc = m_fpc + 32'd4;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic hp, input logic hi,
                       input logic b, input logic e, input logic [31:0] tgt);
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst = r; hold_pc = hp; hold_if = hi; br = b; except = e; pc_branch = tgt;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_total++;
    if (dut_vec !== exp_vec()) $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec());
    else n_pass++;
    n_total++;
    if ({imem_req, inst_valid, pc_out, inst_out} !== 66'h0)
      $display("FAIL reset_values: got req=%b v=%b pc=%h inst=%h want all zero",
               imem_req, inst_valid, pc_out, inst_out);
    else n_pass++;
  endtask

  task automatic test_free_run();
    mem_lat = 1;
    seq_pc  = RESET_PC;
    for (int k = 0; k < 14; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      n_total++;
      if (dut_vec !== exp_vec()) $display("FAIL free_run_model k=%0d: got %h want %h", k, dut_vec, exp_vec());
      else n_pass++;
      n_total++;
      if (k < 3) begin
        if (inst_valid !== 1'b0) $display("FAIL free_run_latency k=%0d: got v=%b want v=0", k, inst_valid);
        else n_pass++;
      end else begin
        if ({inst_valid, pc_out, inst_out} !== {1'b1, seq_pc, seq_pc})
          $display("FAIL free_run_seq k=%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                   k, inst_valid, pc_out, inst_out, seq_pc, seq_pc);
        else n_pass++;
        seq_pc = seq_pc + 32'd4;
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 13; i++) begin
      cycle(1'b0, 1'b0, (i < 3), 1'b0, 1'b0, 32'h0);
      n_total++;
      if (dut_vec !== exp_vec()) $display("FAIL hold_model i=%0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
      n_total++;
      if (i >= 1 && i <= 3) begin
        if ({inst_valid, pc_out} !== {1'b1, seq_pc - 32'd4})
          $display("FAIL hold_freeze i=%0d: got v=%b pc=%h want v=1 pc=%h", i, inst_valid, pc_out, seq_pc - 32'd4);
        else n_pass++;
      end else begin
        if ({inst_valid, pc_out} !== {1'b1, seq_pc})
          $display("FAIL hold_resume i=%0d: got v=%b pc=%h want v=1 pc=%h", i, inst_valid, pc_out, seq_pc);
        else n_pass++;
        seq_pc = seq_pc + 32'd4;
      end
    end
  endtask

  task automatic test_branch();
    mem_lat = 3;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b0, 1'b0, (i == 8), 1'b0, 32'h0000_0100);
      n_total++;
      if (dut_vec !== exp_vec()) $display("FAIL branch_model i=%0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
      if (inst_valid) begin
        n_total++;
        if (pc_out !== seq_pc) $display("FAIL branch_pre_seq: got pc=%h want pc=%h", pc_out, seq_pc);
        else n_pass++;
        seq_pc = seq_pc + 32'd4;
      end
    end
    seq_pc = 32'h0000_0100;
    got    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      n_total++;
      if (dut_vec !== exp_vec()) $display("FAIL branch_model_post i=%0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
      if (inst_valid) begin
        n_total++;
        if ({pc_out, inst_out} !== {seq_pc, seq_pc})
          $display("FAIL branch_target_seq: got pc=%h inst=%h want %h", pc_out, inst_out, seq_pc);
        else n_pass++;
        seq_pc = seq_pc + 32'd4;
        got    = 1'b1;
      end
    end
    n_total++;
    if (!got) $display("FAIL branch_timeout: got no valid output want pc=00000100");
    else n_pass++;
  endtask

  task automatic test_except();
    mem_lat = 1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 1'b0, (i == 5), (i == 5), 32'h0000_0200);
      n_total++;
      if (dut_vec !== exp_vec()) $display("FAIL except_model i=%0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
      if (inst_valid) begin
        n_total++;
        if (pc_out !== seq_pc) $display("FAIL except_pre_seq: got pc=%h want pc=%h", pc_out, seq_pc);
        else n_pass++;
        seq_pc = seq_pc + 32'd4;
      end
    end
    seq_pc = EXC_PC;
    got    = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      n_total++;
      if (dut_vec !== exp_vec()) $display("FAIL except_model_post i=%0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
      if (inst_valid) begin
        n_total++;
        if (pc_out !== seq_pc) $display("FAIL except_vector_seq: got pc=%h want pc=%h", pc_out, seq_pc);
        else n_pass++;
        seq_pc = seq_pc + 32'd4;
        got    = 1'b1;
      end
    end
    n_total++;
    if (!got) $display("FAIL except_timeout: got no valid output want pc=%h", EXC_PC);
    else n_pass++;
  endtask

  task automatic test_empty();
    mem_hold = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 10) mem_hold = 1'b0;
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      n_total++;
      if (dut_vec !== exp_vec()) $display("FAIL empty_model i=%0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
      if (i >= 7 && i <= 10) begin
        n_total++;
        if ({inst_valid, inst_out} !== 33'h0)
          $display("FAIL empty_bubble i=%0d: got v=%b inst=%h want v=0 inst=0", i, inst_valid, inst_out);
        else n_pass++;
      end
      if (inst_valid) begin
        n_total++;
        if (pc_out !== seq_pc) $display("FAIL empty_seq: got pc=%h want pc=%h", pc_out, seq_pc);
        else n_pass++;
        seq_pc = seq_pc + 32'd4;
      end
    end
  endtask

  task automatic test_reset_mid();
    mem_lat = 2;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      n_total++;
      if (dut_vec !== exp_vec()) $display("FAIL rstmid_model i=%0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_total++;
    if (imem_req !== 1'b0) $display("FAIL rstmid_req_in_reset: got req=%b want req=0", imem_req);
    else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_total++;
    if ({inst_valid, inst_out, pc_out, imem_req, imem_addr} !== {65'h0, 1'b1, RESET_PC})
      $display("FAIL rstmid_cleared: got v=%b inst=%h pc=%h req=%b addr=%h want v=0 inst=0 pc=0 req=1 addr=%h",
               inst_valid, inst_out, pc_out, imem_req, imem_addr, RESET_PC);
    else n_pass++;
    seq_pc = RESET_PC;
    got    = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      n_total++;
      if (dut_vec !== exp_vec()) $display("FAIL rstmid_model_post i=%0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
      if (inst_valid) begin
        n_total++;
        if (pc_out !== seq_pc) $display("FAIL rstmid_restart_seq: got pc=%h want pc=%h", pc_out, seq_pc);
        else n_pass++;
        seq_pc = seq_pc + 32'd4;
        got    = 1'b1;
      end
    end
    n_total++;
    if (!got) $display("FAIL rstmid_timeout: got no valid output want pc=%h", RESET_PC);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    mem_gap = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (i % 50 == 0) mem_lat = $urandom_range(1, 4);
      tgt = $urandom() & 32'h0000_FFFC;
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0), tgt);
      n_total++;
      if (dut_vec !== exp_vec()) $display("FAIL random_model i=%0d: got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
    end
    mem_gap = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_free_run();
    test_hold();
    test_branch();
    test_except();
    test_empty();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
